// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO (shift-add mult, restoring div).
// MDU_DIVZERO_EXC_EN: adds div0_o and leaves HI/LO untouched on divide by zero.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
`ifdef MDU_DIVZERO_EXC_EN
  ,
  output logic             div0_o
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  logic               accept;
  logic               is_mult;
  logic               is_multu;
  logic               is_div;
  logic               is_divu;
  logic               is_mthi;
  logic               is_mtlo;
  logic               is_mul_op;
  logic               is_div_op;
  logic               sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign ready_o = (state == S_IDLE);
  assign busy_o  = ~ready_o;
  assign done_o  = (state == S_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
`ifdef MDU_DIVZERO_EXC_EN
  assign div0_o  = (state == S_DONE) && div0;
`endif

  assign accept = start_i && ready_o && !flush_i;

  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    unique case (funct_i)
      F_MULT:  is_mult  = 1'b1;
      F_MULTU: is_multu = 1'b1;
      F_DIV:   is_div   = 1'b1;
      F_DIVU:  is_divu  = 1'b1;
      F_MTHI:  is_mthi  = 1'b1;
      F_MTLO:  is_mtlo  = 1'b1;
      default: ;
    endcase
  end

  assign is_mul_op = is_mult | is_multu;
  assign is_div_op = is_div | is_divu;

  // Signed ops run on magnitudes; signs are re-applied in FIX.
  assign sgn   = is_mult | is_div;
  assign sa    = sgn & rs_i[WIDTH-1];
  assign sb    = sgn & rt_i[WIDTH-1];
  assign mag_a = sa ? -rs_i : rs_i;
  assign mag_b = sb ? -rt_i : rt_i;

  assign mul_sum = {1'b0, acc_hi}
                 + (acc_lo[0] ? {1'b0, opnd}
                              : {(WIDTH+1){1'b0}});

  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd};
  assign div_sub = div_sh[WIDTH-1:0] - opnd;

  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = '0;
    res_lo = '0;
    if (neg_q) prod = -prod;
    if (op_div) begin
      res_lo = neg_q ? -acc_lo : acc_lo;
      res_hi = neg_r ? -acc_hi : acc_hi;
      if (div0) res_lo = '1;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul_op: state_nx = S_MUL;
            is_div_op: state_nx = S_DIV;
            default:   state_nx = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i)          state_nx = S_IDLE;
        else if (cnt == LAST) state_nx = S_FIX;
      end
      S_FIX:   state_nx = flush_i ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && (is_mul_op || is_div_op)) begin
            cnt    <= '0;
            acc_hi <= '0;
            op_div <= is_div_op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= is_div_op && (rt_i == '0);
            acc_lo <= is_mul_op ? mag_b : mag_a;
            opnd   <= is_mul_op ? mag_a : mag_b;
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_IDLE) begin
      if (accept && is_mthi) hi_q <= rs_i;
      if (accept && is_mtlo) lo_q <= rs_i;
    end else if (state == S_FIX && !flush_i) begin
`ifdef MDU_DIVZERO_EXC_EN
      if (!div0) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
`else
      hi_q <= res_hi;
      lo_q <= res_lo;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (WIDTH=32).
// Covers mult/div signs, overflow, divide by zero, MTHI/MTLO, flush and reset.
module tb_mdu_ctrl;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_DIVZERO_EXC_EN
  logic        div0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi;
  logic [31:0] mlo;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .funct_i (funct),
    .rs_i    (rs),
    .rt_i    (rt),
    .flush_i (flush),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
`ifdef MDU_DIVZERO_EXC_EN
    ,
    .div0_o  (div0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [5:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int lat;
    int rbad;
    logic d0;
    lat  = 0;
    rbad = 0;
    d0   = 1'b0;
    @(negedge clk);
    funct = f; rs = a; rt = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_hold_hi"}, hi, mhi);
        chk({tag, "_hold_lo"}, lo, mlo);
      end
      if (ready) rbad++;
      if (done) begin
        lat = k;
`ifdef MDU_DIVZERO_EXC_EN
        d0 = div0;
`endif
        break;
      end
    end
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_busy"}, rbad, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
`ifdef MDU_DIVZERO_EXC_EN
    chk({tag, "_div0"}, d0,
        (f == F_DIV || f == F_DIVU) && b == 32'h0);
`else
    chk({tag, "_nodiv0"}, d0, 1'b0);
`endif
    mhi = eh;
    mlo = el;
    @(negedge clk);
    chk({tag, "_rdy_after"}, ready, 1'b1);
    chk({tag, "_done_after"}, done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    funct = 6'h0;
    rs    = 32'h0;
    rt    = 32'h0;
    mhi   = 32'h0;
    mlo   = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst_n = 1'b1;

    run_op("mult", F_MULT, 32'hFFFFFFFF, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'h2,
           32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'h2,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000);
    run_op("divu", F_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14);
`ifdef MDU_DIVZERO_EXC_EN
    run_op("divz", F_DIVU, 32'd7, 32'd0, mhi, mlo);
`else
    run_op("divz", F_DIVU, 32'd7, 32'd0,
           32'd7, 32'hFFFFFFFF);
`endif

    // MTHI, then MULTU in the very next cycle
    @(negedge clk);
    funct = F_MTHI; rs = 32'h12345678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_done", done, 1'b0);
    chk("mthi_ready", ready, 1'b1);
    mhi = 32'h12345678;
    run_op("multu_b2b", F_MULTU, 32'd3, 32'd5,
           32'h0, 32'd15);

    @(negedge clk);
    funct = F_MTLO; rs = 32'hAAAA5555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'hAAAA5555);
    chk("mtlo_hi", hi, mhi);
    mlo = 32'hAAAA5555;

    @(negedge clk);
    funct = F_ADD; rs = 32'h11111111; rt = 32'h2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("unsup_ready", ready, 1'b1);
    chk("unsup_hi", hi, mhi);
    chk("unsup_lo", lo, mlo);

    @(negedge clk);
    funct = F_MTHI; rs = 32'hDEADBEEF;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flstart_hi", hi, mhi);
    chk("flstart_ready", ready, 1'b1);

    // flush mid-divide at T+10
    @(negedge clk);
    funct = F_DIVU; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", ready, 1'b1);
    chk("flush_done", done, 1'b0);
    chk("flush_hi", hi, mhi);
    chk("flush_lo", lo, mlo);
    run_op("after_flush", F_MULTU, 32'd6, 32'd7,
           32'h0, 32'd42);

    // reset mid-divide at T+10
    @(negedge clk);
    funct = F_DIVU; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    mhi = 32'h0;
    mlo = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", F_MULT, 32'hFFFFFFFD, 32'd5,
           32'hFFFFFFFF, 32'hFFFFFFF1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
